// File: rtl/mips_mem_responder_pkg.sv
// Shared constants and helpers for the MIPS memory responder.
package mips_mem_responder_pkg;

    // Responder FSM state encodings (3-bit, kept as plain constants so they
    // line up with the older define-based FSM encodings).
    localparam logic [2:0] MEMR_IDLE   = 3'd0;
    localparam logic [2:0] MEMR_WAIT   = 3'd1;
    localparam logic [2:0] MEMR_ACCESS = 3'd2;
    localparam logic [2:0] MEMR_RESP   = 3'd3;
    localparam logic [2:0] MEMR_FAULT  = 3'd4;

    // A request is serviceable only if it is word-aligned and falls inside
    // the 2**dl2-word RAM (every byte-address bit above the index is zero).
    function automatic logic addr_valid(input logic [31:0] a, input int dl2);
        return (a[1:0] == 2'b00) && ((a >> (dl2 + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/mips_ram_sp.sv
// Synchronous single-port word RAM with a registered read port.
// The array itself is never reset; only the read register is.
module mips_ram_sp #(
    parameter int    DEPTH_LOG2 = 8,
    parameter string MEM_INIT   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Write port: array update on an enabled write.
    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
    end

    // Read register: only an enabled read updates it, so it holds across
    // writes and idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= 32'd0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS datapath: accepts one word
// request at a time, inserts WAIT_STATES wait cycles, performs a single RAM
// access and reports completion with a one-cycle ready (or err) pulse.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int    DEPTH_LOG2  = 8,
    parameter int    WAIT_STATES = 2,
    parameter string MEM_INIT    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]            state, state_nx;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic                  ok;
    logic                  accept;
    logic                  ram_en;
    logic                  ram_we;

    assign ok     = addr_valid(addr, DEPTH_LOG2);
    assign accept = (state == MEMR_IDLE) && req && ok;

    // Next-state decode; inputs only matter while idle.
    always_comb begin
        state_nx = state;
        case (state)
            MEMR_IDLE: begin
                if (req) begin
                    if (!ok)                 state_nx = MEMR_FAULT;
                    else if (WAIT_STATES > 0) state_nx = MEMR_WAIT;
                    else                     state_nx = MEMR_ACCESS;
                end
            end
            MEMR_WAIT:   if (cnt == 4'd0) state_nx = MEMR_ACCESS;
            MEMR_ACCESS: state_nx = MEMR_RESP;
            MEMR_RESP:   state_nx = MEMR_IDLE;
            MEMR_FAULT:  state_nx = MEMR_IDLE;
            default:     state_nx = MEMR_IDLE;
        endcase
    end

    // State plus flopped status outputs, decoded from the next state so the
    // pulses line up with RESP/FAULT without any combinational output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEMR_IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == MEMR_RESP);
            err   <= (state_nx == MEMR_FAULT);
            busy  <= (state_nx != MEMR_IDLE);
        end
    end

    // Wait-state counter: loaded on accept, counts down to zero in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= 4'd0;
        else if (accept)
            cnt <= CNT_INIT;
        else if (state == MEMR_WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Request capture; rejected requests latch nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            idx_q   <= addr[DEPTH_LOG2+1:2];
            we_q    <= we;
            wdata_q <= wdata;
        end
    end

    // The RAM is touched only in ACCESS, so a reset before then aborts a write.
    assign ram_en = (state == MEMR_ACCESS);
    assign ram_we = ram_en && we_q;

    mips_ram_sp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .MEM_INIT   (MEM_INIT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: table of transactions checked through a
// response scoreboard, plus hand sequences for reset and busy corner cases.
module tb_mips_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic [31:0] rdata0;
    logic        ready0, busy0, err0;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS), .MEM_INIT("")) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err));

    mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .MEM_INIT("")) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit e; logic [31:0] x; int due; } exp_t;
    exp_t q[$];

    typedef struct { bit w; logic [31:0] a; logic [31:0] d; bit e; logic [31:0] x; } vec_t;
    vec_t tbl[13];

    // Scoreboard: every ready/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ready || err) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL spurious: ready=%0b err=%0b at cyc %0d, want no response", ready, err, cyc);
            end else begin
                automatic exp_t ex = q.pop_front();
                if (err !== ex.e || ready !== !ex.e || cyc != ex.due || rdata !== ex.x) begin
                    fails++;
                    $display("FAIL resp: err=%0b ready=%0b cyc=%0d rdata=%h, want err=%0b cyc=%0d rdata=%h",
                             err, ready, cyc, rdata, ex.e, ex.due, ex.x);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit e, input logic [31:0] x);
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        q.push_back('{e: e, x: x, due: cyc + (e ? 1 : WS + 2)});
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    // Single transaction on the zero-wait instance; checks latency and data.
    task automatic run0(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] x);
        int c0, seen;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; c0 = cyc;
        @(posedge clk); #1;
        req0 = 1'b0;
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            @(negedge clk);
            if (ready0) begin
                seen = cyc;
                if (chk) check("ws0_rdata", rdata0, x);
            end
        end
        check("ws0_latency", 32'(seen), 32'(c0 + 2));
    endtask

    initial begin
        int busy_hi;

        tbl[0]  = '{1, 32'h10,       32'hDEADBEEF, 0, 32'h0};
        tbl[1]  = '{0, 32'h10,       32'h0,        0, 32'hDEADBEEF};
        tbl[2]  = '{1, 32'h13,       32'h0BAD0BAD, 1, 32'hDEADBEEF};
        tbl[3]  = '{0, 32'h10,       32'h0,        0, 32'hDEADBEEF};
        tbl[4]  = '{1, 32'h400,      32'h0BAD0BAD, 1, 32'hDEADBEEF};
        tbl[5]  = '{1, 32'h3FC,      32'hA5A5A5A5, 0, 32'hDEADBEEF};
        tbl[6]  = '{0, 32'h3FC,      32'h0,        0, 32'hA5A5A5A5};
        tbl[7]  = '{1, 32'h24,       32'h11111111, 0, 32'hA5A5A5A5};
        tbl[8]  = '{0, 32'h24,       32'h0,        0, 32'h11111111};
        tbl[9]  = '{0, 32'h80000010, 32'h0,        1, 32'h11111111};
        tbl[10] = '{1, 32'h30,       32'h0BADF00D, 0, 32'h11111111};
        tbl[11] = '{1, 32'h10,       32'hCAFEF00D, 0, 32'h11111111};
        tbl[12] = '{0, 32'h10,       32'h0,        0, 32'hCAFEF00D};

        // Reset, then quiet idle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_rdata", rdata,      32'd0);
        busy_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        check("idle_busy", 32'(busy_hi), 32'd0);

        // Table-driven transactions.
        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].x);
            wait_idle();
        end

        // Requests while busy are ignored.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        q.push_back('{e: 1'b0, x: 32'hCAFEF00D, due: cyc + WS + 2});
        @(posedge clk); #1;
        addr = 32'h24; wdata = 32'h1;
        @(negedge clk);
        check("busy_pending", 32'(busy), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle();
        issue(0, 32'h24, 32'h0, 0, 32'h11111111);
        wait_idle();
        issue(0, 32'h20, 32'h0, 0, 32'h00000055);
        wait_idle();

        // Reset while in WAIT aborts the write and suppresses ready.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("wait_rst_busy",  32'(busy), 32'd0);
        check("wait_rst_rdata", rdata,     32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 32'h30, 32'h0, 0, 32'h0BADF00D);
        wait_idle();

        // Reset in RESP: ready suppressed, but the write already landed.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h34; wdata = 32'h00000077;
        repeat (4) @(posedge clk);
        #1 req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("resp_rst_ready", 32'(ready), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 32'h34, 32'h0, 0, 32'h00000077);
        wait_idle();

        // Zero wait states.
        run0(1, 32'h0, 32'h2002000A, 0, 32'h0);
        run0(0, 32'h0, 32'h0,        1, 32'h2002000A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
